// File: rtl/d16_dbus.sv
// d16 data-bus slave: decodes each core access to a synchronous data RAM or
// a small memory-mapped I/O page (TX FIFO, RX window, cycle counter).
// Reads have a fixed one-cycle latency and no side effects.
// Ports:
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   d16_we/d16_a/d16_di      core write strobe, word address, write data
//   d16_do                   registered read data to core
//   tx_data/tx_valid/tx_ready  TX FIFO head stream
//   rx_data/rx_valid/rx_ready  RX producer window, rx_ready is a pop pulse
module d16_dbus #(
    parameter int unsigned RAM_AW  = 10,
    parameter logic [15:0] IO_BASE = 16'hFF00,
    parameter int unsigned TX_LOG2 = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        d16_we,
    input  logic [15:0] d16_a,
    input  logic [15:0] d16_di,
    output logic [15:0] d16_do,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int unsigned DW        = 16;
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam int unsigned TX_DEPTH  = 1 << TX_LOG2;
    localparam int unsigned PW        = TX_LOG2 + 1;

    localparam logic [15:0] OFF_TX     = 16'd0;
    localparam logic [15:0] OFF_STATUS = 16'd1;
    localparam logic [15:0] OFF_RX     = 16'd2;
    localparam logic [15:0] OFF_CYCLE  = 16'd3;
    localparam logic [15:0] OFF_CTRL   = 16'd4;

    logic [DW-1:0]     ram_q  [RAM_DEPTH];
    logic [DW-1:0]     fifo_q [TX_DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic [DW-1:0]     cycle_q, cycle_d;
    logic              rx_ready_q, rx_ready_d;
    logic [DW-1:0]     d16_do_q, d16_do_d;

    logic              is_io;
    logic [15:0]       io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              push, pop, push_ok, ovf_set, ovf_clr, cycle_we;
    logic [PW-1:0]     tx_lvl;
    logic              tx_empty, tx_full;

    // Address decode and FIFO status
    always_comb begin
        is_io    = (d16_a >= IO_BASE);
        io_off   = d16_a - IO_BASE;
        ram_idx  = d16_a[RAM_AW-1:0];
        ram_we   = d16_we && !is_io;

        tx_lvl   = wr_ptr_q - rd_ptr_q;
        tx_empty = (tx_lvl == '0);
        tx_full  = (tx_lvl == PW'(TX_DEPTH));

        push     = d16_we && is_io && (io_off == OFF_TX);
        pop      = !tx_empty && tx_ready;
        // A full FIFO still accepts a push when the head leaves this cycle
        push_ok  = push && (!tx_full || pop);
        ovf_set  = push && tx_full && !pop;
        ovf_clr  = d16_we && is_io && (io_off == OFF_CTRL) && d16_di[0];
        cycle_we = d16_we && is_io && (io_off == OFF_CYCLE);
    end

    // Next-state for FIFO pointers, overflow flag, counter, rx pop pulse
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        cycle_d    = cycle_q + 16'd1;
        rx_ready_d = 1'b0;

        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        // Set has priority over a same-cycle clear
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
        if (cycle_we) cycle_d = d16_di;
        rx_ready_d = d16_we && is_io && (io_off == OFF_RX) && rx_valid;
    end

    // Read mux; uses pre-edge state so write cycles return the old value
    always_comb begin
        d16_do_d = '0;
        if (!is_io) begin
            d16_do_d = ram_q[ram_idx];
        end else begin
            case (io_off)
                OFF_STATUS: d16_do_d = {4'b0, 4'(tx_lvl), 4'b0,
                                        ovf_q, rx_valid, tx_empty, tx_full};
                OFF_RX:     d16_do_d = rx_data;
                OFF_CYCLE:  d16_do_d = cycle_q;
                default:    d16_do_d = '0;
            endcase
        end
    end

    // Control/state registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            cycle_q    <= '0;
            rx_ready_q <= 1'b0;
            d16_do_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            cycle_q    <= cycle_d;
            rx_ready_q <= rx_ready_d;
            d16_do_q   <= d16_do_d;
        end
    end

    // Storage arrays are not reset; pointers define validity
    always_ff @(posedge sys_clk) begin
        if (ram_we) ram_q[ram_idx] <= d16_di;
        if (push_ok) fifo_q[wr_ptr_q[TX_LOG2-1:0]] <= d16_di;
    end

    assign d16_do   = d16_do_q;
    assign rx_ready = rx_ready_q;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? '0 : fifo_q[rd_ptr_q[TX_LOG2-1:0]];

endmodule

// File: tb/tb_d16_dbus.sv
// Directed self-checking bench for d16_dbus.
module tb_d16_dbus;

    logic        sys_clk;
    logic        sys_rst;
    logic        d16_we;
    logic [15:0] d16_a;
    logic [15:0] d16_di;
    logic [15:0] d16_do;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] IO = 16'hFF00;

    d16_dbus dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .d16_we   (d16_we),
        .d16_a    (d16_a),
        .d16_di   (d16_di),
        .d16_do   (d16_do),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        d16_we = 1'b1; d16_a = a; d16_di = v;
        tick();
        d16_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        d16_we = 1'b0; d16_a = a;
        tick();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        checks++; if (d16_do !== 16'h0000) begin errors++; $display("FAIL reset_do: got %h exp 0000", d16_do); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL reset_tx_data: got %h exp 0000", tx_data); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b exp 0", rx_ready); end
        sys_rst = 1'b0;
        rd(IO + 16'd3);
        checks++; if (d16_do !== 16'h0000) begin errors++; $display("FAIL reset_cycle: got %h exp 0000", d16_do); end
        rd(IO + 16'd1);
        checks++; if (d16_do !== 16'h0002) begin errors++; $display("FAIL reset_status: got %h exp 0002", d16_do); end
    endtask

    task automatic test_ram();
        wr(16'h0005, 16'h1234);
        rd(16'h0005);
        checks++; if (d16_do !== 16'h1234) begin errors++; $display("FAIL ram_read: got %h exp 1234", d16_do); end
        rd(16'h0405);
        checks++; if (d16_do !== 16'h1234) begin errors++; $display("FAIL ram_alias: got %h exp 1234", d16_do); end
        wr(16'h0005, 16'hABCD);
        checks++; if (d16_do !== 16'h1234) begin errors++; $display("FAIL ram_read_first: got %h exp 1234", d16_do); end
        rd(16'h0005);
        checks++; if (d16_do !== 16'hABCD) begin errors++; $display("FAIL ram_new: got %h exp abcd", d16_do); end
        rd(IO + 16'd7);
        checks++; if (d16_do !== 16'h0000) begin errors++; $display("FAIL io_unmapped: got %h exp 0000", d16_do); end
    endtask

    task automatic test_tx_overflow();
        logic [15:0] exp_q [4];
        exp_q[0] = 16'hA001; exp_q[1] = 16'hB002; exp_q[2] = 16'hC003; exp_q[3] = 16'hD004;
        tx_ready = 1'b0;
        wr(IO, exp_q[0]);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_rise: got %b exp 1", tx_valid); end
        checks++; if (tx_data !== 16'hA001) begin errors++; $display("FAIL tx_head: got %h exp a001", tx_data); end
        for (int i = 1; i < 4; i++) wr(IO, exp_q[i]);
        rd(IO + 16'd1);
        checks++; if (d16_do !== 16'h0401) begin errors++; $display("FAIL tx_status_full: got %h exp 0401", d16_do); end
        wr(IO, 16'hE005);
        rd(IO + 16'd1);
        checks++; if (d16_do !== 16'h0409) begin errors++; $display("FAIL tx_status_ovf: got %h exp 0409", d16_do); end
        rd(IO);
        checks++; if (d16_do !== 16'h0000) begin errors++; $display("FAIL tx_data_read: got %h exp 0000", d16_do); end
        d16_a = 16'h0000;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin errors++; $display("FAIL tx_drain%0d: got %b/%h exp 1/%h", i, tx_valid, tx_data, exp_q[i]); end
            tick();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drain_empty: got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
        rd(IO + 16'd1);
        checks++; if (d16_do !== 16'h000A) begin errors++; $display("FAIL tx_ovf_sticky: got %h exp 000a", d16_do); end
        wr(IO + 16'd4, 16'h0001);
        rd(IO + 16'd1);
        checks++; if (d16_do !== 16'h0002) begin errors++; $display("FAIL tx_ovf_clear: got %h exp 0002", d16_do); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_q [4];
        exp_q[0] = 16'h0022; exp_q[1] = 16'h0033; exp_q[2] = 16'h0044; exp_q[3] = 16'h00EE;
        tx_ready = 1'b0;
        wr(IO, 16'h0011);
        for (int i = 0; i < 3; i++) wr(IO, exp_q[i]);
        tx_ready = 1'b1;
        wr(IO, 16'h00EE);
        tx_ready = 1'b0;
        rd(IO + 16'd1);
        checks++; if (d16_do !== 16'h0401) begin errors++; $display("FAIL fpp_status: got %h exp 0401", d16_do); end
        d16_a = 16'h0000;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin errors++; $display("FAIL fpp_drain%0d: got %b/%h exp 1/%h", i, tx_valid, tx_data, exp_q[i]); end
            tick();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        rx_valid = 1'b1;
        rx_data  = 16'hBEEF;
        rd(IO + 16'd2);
        checks++; if (d16_do !== 16'hBEEF) begin errors++; $display("FAIL rx_read: got %h exp beef", d16_do); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_read_no_pop: got %b exp 0", rx_ready); end
        rd(IO + 16'd1);
        checks++; if (d16_do !== 16'h0006) begin errors++; $display("FAIL rx_status: got %h exp 0006", d16_do); end
        wr(IO + 16'd2, 16'h0000);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_pulse: got %b exp 1", rx_ready); end
        rd(16'h0000);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_pulse_end: got %b exp 0", rx_ready); end
        d16_we = 1'b1; d16_a = IO + 16'd2;
        tick();
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_b2b_1: got %b exp 1", rx_ready); end
        tick();
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_b2b_2: got %b exp 1", rx_ready); end
        d16_we = 1'b0;
        tick();
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_b2b_end: got %b exp 0", rx_ready); end
        rx_valid = 1'b0;
        wr(IO + 16'd2, 16'h0000);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_no_valid: got %b exp 0", rx_ready); end
        tick();
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_no_valid2: got %b exp 0", rx_ready); end
    endtask

    task automatic test_cycle();
        logic [15:0] exp_c [3];
        exp_c[0] = 16'hFFFE; exp_c[1] = 16'hFFFF; exp_c[2] = 16'h0000;
        wr(IO + 16'd3, 16'hFFFE);
        d16_a = IO + 16'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (d16_do !== exp_c[i]) begin errors++; $display("FAIL cycle_%0d: got %h exp %h", i, d16_do, exp_c[i]); end
        end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(IO, 16'(16'h0100 + i));
        tx_ready = 1'b1;
        rd(16'h0000);
        tx_ready = 1'b0;
        rd(IO + 16'd1);
        checks++; if (d16_do !== 16'h0308) begin errors++; $display("FAIL mid_pre_status: got %h exp 0308", d16_do); end
        // Reset coincides with a pop write so any rx_ready pulse must be cancelled
        rx_valid = 1'b1;
        sys_rst = 1'b1;
        d16_we = 1'b1; d16_a = IO + 16'd2;
        tick();
        d16_we = 1'b0;
        sys_rst = 1'b0;
        rx_valid = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %b exp 0", tx_valid); end
        checks++; if (d16_do !== 16'h0000) begin errors++; $display("FAIL mid_do: got %h exp 0000", d16_do); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL mid_rx_ready: got %b exp 0", rx_ready); end
        rd(IO + 16'd3);
        checks++; if (d16_do !== 16'h0000) begin errors++; $display("FAIL mid_cycle0: got %h exp 0000", d16_do); end
        rd(IO + 16'd3);
        checks++; if (d16_do !== 16'h0001) begin errors++; $display("FAIL mid_cycle1: got %h exp 0001", d16_do); end
        rd(IO + 16'd1);
        checks++; if (d16_do !== 16'h0002) begin errors++; $display("FAIL mid_status: got %h exp 0002", d16_do); end
    endtask

    initial begin
        sys_rst  = 1'b1;
        d16_we   = 1'b0;
        d16_a    = 16'h0000;
        d16_di   = 16'h0000;
        tx_ready = 1'b0;
        rx_data  = 16'h0000;
        rx_valid = 1'b0;
        test_reset();
        test_ram();
        test_tx_overflow();
        test_full_push_pop();
        test_rx();
        test_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
